// File: rtl/sprite_pkg.sv
// Shared types and constants for the animated sprite overlay.
package sprite_pkg;
   localparam int COORD_W     = 10;
   localparam int TRANS_A_DEF = 1;
   localparam int TRANS_B_DEF = 6;

   typedef logic [COORD_W-1:0] coord_t;

   typedef enum logic [1:0] {
      IDLE,
      CHARGE,
      FULL,
      RELEASE
   } anim_state_t;
endpackage

// File: rtl/sprite_addr_gen.sv
// Window test and texel address generation for one animation frame.
// Produces a registered ROM address and a registered in-window flag.
module sprite_addr_gen
   import sprite_pkg::*;
#(
   parameter int unsigned X0          = 428,
   parameter int unsigned Y0          = 327,
   parameter int unsigned SPR_W       = 75,
   parameter int unsigned SPR_H       = 77,
   parameter int unsigned SCALE_SHIFT = 1,
   parameter int          ADDR_W      = 15,
   parameter int          FRM_W       = 2
) (
   input  logic              vga_clk,
   input  logic              reset_n,
   input  coord_t            draw_x,
   input  coord_t            draw_y,
   input  logic [FRM_W-1:0]  frame,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              in_win
);
   localparam int unsigned WIN_W    = SPR_W << SCALE_SHIFT;
   localparam int unsigned WIN_H    = SPR_H << SCALE_SHIFT;
   localparam int unsigned FRAME_SZ = SPR_W * SPR_H;

   logic [31:0]       x_ext, y_ext, u, v;
   logic              in_win_d, in_win_q;
   logic [ADDR_W-1:0] rom_addr_d, rom_addr_q;

   always_comb begin
      x_ext    = 32'(draw_x);
      y_ext    = 32'(draw_y);
      in_win_d = (x_ext >= X0) && (x_ext < X0 + WIN_W) &&
                 (y_ext >= Y0) && (y_ext < Y0 + WIN_H);
      u        = (x_ext - X0) >> SCALE_SHIFT;
      v        = (y_ext - Y0) >> SCALE_SHIFT;
      rom_addr_d = '0;
      // Full 32-bit multiply-add, truncated to the ROM address width.
      if (in_win_d) begin
         rom_addr_d = ADDR_W'(32'(frame) * FRAME_SZ + v * SPR_W + u);
      end
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         rom_addr_q <= '0;
         in_win_q   <= 1'b0;
      end else begin
         rom_addr_q <= rom_addr_d;
         in_win_q   <= in_win_d;
      end
   end

   assign rom_addr = rom_addr_q;
   assign in_win   = in_win_q;
endmodule

// File: rtl/sprite_anim_overlay.sv
// Animated sprite overlay: address pipeline, ROM-latency alignment and the
// bow-charge state machine (hold to draw, release to fire).
module sprite_anim_overlay
   import sprite_pkg::*;
#(
   parameter int unsigned X0          = 428,
   parameter int unsigned Y0          = 327,
   parameter int unsigned SPR_W       = 75,
   parameter int unsigned SPR_H       = 77,
   parameter int unsigned SCALE_SHIFT = 1,
   parameter int          FRAMES      = 4,
   parameter int          IDX_W       = 3,
   parameter int          TRANS_A     = TRANS_A_DEF,
   parameter int          TRANS_B     = TRANS_B_DEF,
   parameter int          ROM_LAT     = 1,
   parameter int          STEP_FR     = 8,
   parameter int          REL_FR      = 6,
   parameter int          ADDR_W      = $clog2(FRAMES * SPR_W * SPR_H),
   localparam int         CHG_W       = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
   input  logic               vga_clk,
   input  logic               reset_n,
   input  logic [COORD_W-1:0] DrawX,
   input  logic [COORD_W-1:0] DrawY,
   input  logic               blank,
   input  logic               frame_start,
   input  logic               draw_req,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [IDX_W-1:0]   rom_q,
   output logic [IDX_W-1:0]   pix_idx,
   output logic               pix_opaque,
   output logic               blank_d,
   output logic [CHG_W-1:0]   charge,
   output logic               fired
);
   localparam int CNT_MAX = (STEP_FR > REL_FR) ? STEP_FR : REL_FR;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   anim_state_t       state_d, state_q;
   logic [CNT_W-1:0]  step_d, step_q;
   logic [CHG_W-1:0]  charge_d, charge_q, charge_inc;
   logic [CHG_W-1:0]  disp_frame_d, disp_frame_q;
   logic              fired_d, fired_q;

   logic              in_win_s1;
   logic [ROM_LAT-1:0] win_dl_d, win_dl_q;
   logic [ROM_LAT:0]  blank_dl_d, blank_dl_q;
   logic [IDX_W-1:0]  pix_idx_d, pix_idx_q;
   logic              pix_opaque_d, pix_opaque_q;
   logic              blank_d_d, blank_d_q;

   sprite_addr_gen #(
      .X0          (X0),
      .Y0          (Y0),
      .SPR_W       (SPR_W),
      .SPR_H       (SPR_H),
      .SCALE_SHIFT (SCALE_SHIFT),
      .ADDR_W      (ADDR_W),
      .FRM_W       (CHG_W)
   ) u_addr_gen (
      .vga_clk  (vga_clk),
      .reset_n  (reset_n),
      .draw_x   (DrawX),
      .draw_y   (DrawY),
      .frame    (disp_frame_q),
      .rom_addr (rom_addr),
      .in_win   (in_win_s1)
   );

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      charge_d   = charge_q;
      fired_d    = 1'b0;
      charge_inc = charge_q + 1'b1;
      // Displayed frame only moves at frame boundaries to avoid tearing.
      disp_frame_d = frame_start ? charge_q : disp_frame_q;
      case (state_q)
         IDLE: begin
            charge_d = '0;
            if (draw_req) begin
               state_d = CHARGE;
               step_d  = '0;
            end
         end
         CHARGE, FULL: begin
            if (!draw_req) begin
               state_d  = RELEASE;
               step_d   = '0;
               charge_d = '0;
               fired_d  = 1'b1;
            end else if (state_q == CHARGE && frame_start) begin
               if (step_q == CNT_W'(STEP_FR - 1)) begin
                  step_d   = '0;
                  charge_d = charge_inc;
                  if (charge_inc == CHG_W'(FRAMES - 1)) state_d = FULL;
               end else begin
                  step_d = step_q + 1'b1;
               end
            end
         end
         RELEASE: begin
            if (frame_start) begin
               if (step_q == CNT_W'(REL_FR - 1)) begin
                  state_d = IDLE;
                  step_d  = '0;
               end else begin
                  step_d = step_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      win_dl_d[0]   = in_win_s1;
      for (int i = 1; i < ROM_LAT; i++) win_dl_d[i] = win_dl_q[i-1];
      blank_dl_d[0] = blank;
      for (int i = 1; i <= ROM_LAT; i++) blank_dl_d[i] = blank_dl_q[i-1];
      pix_idx_d    = win_dl_q[ROM_LAT-1] ? rom_q : '0;
      pix_opaque_d = win_dl_q[ROM_LAT-1] && (rom_q != IDX_W'(TRANS_A)) &&
                     (rom_q != IDX_W'(TRANS_B));
      blank_d_d    = blank_dl_q[ROM_LAT];
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         step_q       <= '0;
         charge_q     <= '0;
         disp_frame_q <= '0;
         fired_q      <= 1'b0;
         win_dl_q     <= '0;
         blank_dl_q   <= '0;
         pix_idx_q    <= '0;
         pix_opaque_q <= 1'b0;
         blank_d_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         step_q       <= step_d;
         charge_q     <= charge_d;
         disp_frame_q <= disp_frame_d;
         fired_q      <= fired_d;
         win_dl_q     <= win_dl_d;
         blank_dl_q   <= blank_dl_d;
         pix_idx_q    <= pix_idx_d;
         pix_opaque_q <= pix_opaque_d;
         blank_d_q    <= blank_d_d;
      end
   end

   assign pix_idx    = pix_idx_q;
   assign pix_opaque = pix_opaque_q;
   assign blank_d    = blank_d_q;
   assign charge     = charge_q;
   assign fired      = fired_q;
endmodule

// File: tb/tb_sprite_anim_overlay.sv
// Directed bench: default instance plus a ROM_LAT=2 / unscaled instance.
module tb_sprite_anim_overlay;
   logic        vga_clk, reset_n;
   logic [9:0]  DrawX, DrawY;
   logic        blank, frame_start, draw_req;
   logic [2:0]  rom_q0, rom_q1;
   logic [14:0] rom_addr0, rom_addr1;
   logic [2:0]  pix_idx0, pix_idx1;
   logic        pix_opaque0, pix_opaque1, blank_d0, blank_d1, fired0, fired1;
   logic [1:0]  charge0, charge1;
   int          n_cmp = 0;
   int          n_bad = 0;

   sprite_anim_overlay dut0 (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
      .blank(blank), .frame_start(frame_start), .draw_req(draw_req),
      .rom_addr(rom_addr0), .rom_q(rom_q0), .pix_idx(pix_idx0),
      .pix_opaque(pix_opaque0), .blank_d(blank_d0), .charge(charge0), .fired(fired0)
   );

   sprite_anim_overlay #(.ROM_LAT(2), .SCALE_SHIFT(0)) dut1 (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
      .blank(blank), .frame_start(frame_start), .draw_req(draw_req),
      .rom_addr(rom_addr1), .rom_q(rom_q1), .pix_idx(pix_idx1),
      .pix_opaque(pix_opaque1), .blank_d(blank_d1), .charge(charge1), .fired(fired1)
   );

   initial vga_clk = 1'b0;
   always #5 vga_clk = ~vga_clk;

   task automatic tick();
      @(posedge vga_clk);
      #1;
   endtask

   task automatic pulse_frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b0; blank = 1'b1; frame_start = 1'b0; draw_req = 1'b0;
      DrawX = 10'd440; DrawY = 10'd340; rom_q0 = 3'd3; rom_q1 = 3'd3;
      tick(); tick(); tick();
      n_cmp++;
      if ({rom_addr0, pix_idx0, pix_opaque0, blank_d0, charge0, fired0} !== 24'd0) begin
         n_bad++;
         $display("FAIL reset_dut0: got addr=%0d idx=%0d op=%b bd=%b ch=%0d f=%b want all 0",
                  rom_addr0, pix_idx0, pix_opaque0, blank_d0, charge0, fired0);
      end
      n_cmp++;
      if ({rom_addr1, pix_idx1, pix_opaque1, blank_d1, charge1, fired1} !== 24'd0) begin
         n_bad++;
         $display("FAIL reset_dut1: got addr=%0d idx=%0d op=%b bd=%b ch=%0d f=%b want all 0",
                  rom_addr1, pix_idx1, pix_opaque1, blank_d1, charge1, fired1);
      end
      reset_n = 1'b1;
      tick();
      $display("test_reset: done");
   endtask

   task automatic test_addr();
      int xs[8]  = '{428, 430, 577, 578, 427, 502, 503, 428};
      int ys[8]  = '{327, 329, 480, 480, 327, 403, 404, 481};
      int e0s[8] = '{0, 76, 5774, 0, 0, 2887, 2887, 0};
      int e1s[8] = '{0, 152, 0, 0, 0, 5774, 0, 0};
      for (int i = 0; i < 8; i++) begin
         DrawX = 10'(xs[i]); DrawY = 10'(ys[i]);
         tick();
         n_cmp++;
         if (rom_addr0 !== 15'(e0s[i])) begin
            n_bad++;
            $display("FAIL addr0_%0d: (%0d,%0d) got %0d want %0d", i, xs[i], ys[i], rom_addr0, e0s[i]);
         end
         n_cmp++;
         if (rom_addr1 !== 15'(e1s[i])) begin
            n_bad++;
            $display("FAIL addr1_%0d: (%0d,%0d) got %0d want %0d", i, xs[i], ys[i], rom_addr1, e1s[i]);
         end
         $display("test_addr: (%0d,%0d) addr0=%0d addr1=%0d", xs[i], ys[i], rom_addr0, rom_addr1);
      end
   endtask

   task automatic test_latency();
      logic exp_op;
      rom_q1 = 3'd3; DrawX = 10'd0; DrawY = 10'd340;
      repeat (5) tick();
      DrawX = 10'd440;
      tick();
      n_cmp++;
      if (rom_addr1 !== 15'd987) begin
         n_bad++;
         $display("FAIL lat_addr1: got %0d want 987", rom_addr1);
      end
      DrawX = 10'd0;
      for (int k = 1; k <= 6; k++) begin
         if (k > 1) tick();
         exp_op = (k == 4);
         n_cmp++;
         if (pix_opaque1 !== exp_op) begin
            n_bad++;
            $display("FAIL lat_opaque1_k%0d: got %b want %b", k, pix_opaque1, exp_op);
         end
      end
      $display("test_latency: done");
   endtask

   task automatic test_opacity();
      int  vals[6] = '{1, 6, 3, 0, 7, 2};
      logic ops[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      DrawX = 10'd440; DrawY = 10'd340; rom_q0 = 3'd3;
      repeat (3) tick();
      for (int i = 0; i < 6; i++) begin
         rom_q0 = 3'(vals[i]);
         tick();
         n_cmp++;
         if (pix_opaque0 !== ops[i] || pix_idx0 !== 3'(vals[i])) begin
            n_bad++;
            $display("FAIL opacity_q%0d: got op=%b idx=%0d want op=%b idx=%0d",
                     vals[i], pix_opaque0, pix_idx0, ops[i], vals[i]);
         end
         $display("test_opacity: rom_q=%0d op=%b idx=%0d", vals[i], pix_opaque0, pix_idx0);
      end
      rom_q0 = 3'd3;
      tick();
      DrawX = 10'd427;
      tick();
      DrawX = 10'd440;
      tick();
      n_cmp++;
      if (pix_opaque0 !== 1'b1) begin
         n_bad++;
         $display("FAIL edge_n2: got %b want 1", pix_opaque0);
      end
      tick();
      n_cmp++;
      if (pix_opaque0 !== 1'b0 || pix_idx0 !== 3'd0) begin
         n_bad++;
         $display("FAIL edge_n3: got op=%b idx=%0d want op=0 idx=0", pix_opaque0, pix_idx0);
      end
      tick();
      n_cmp++;
      if (pix_opaque0 !== 1'b1) begin
         n_bad++;
         $display("FAIL edge_n4: got %b want 1", pix_opaque0);
      end
   endtask

   task automatic test_blank();
      logic pat[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 10; i++) begin
         blank = pat[i];
         tick();
         if (i >= 2) begin
            n_cmp++;
            if (blank_d0 !== pat[i-2]) begin
               n_bad++;
               $display("FAIL blank_d0_%0d: got %b want %b", i, blank_d0, pat[i-2]);
            end
         end
         if (i >= 3) begin
            n_cmp++;
            if (blank_d1 !== pat[i-3]) begin
               n_bad++;
               $display("FAIL blank_d1_%0d: got %b want %b", i, blank_d1, pat[i-3]);
            end
         end
      end
      blank = 1'b1;
      $display("test_blank: done");
   endtask

   task automatic test_release();
      DrawX = 10'd428; DrawY = 10'd327;
      draw_req = 1'b1;
      tick();
      repeat (16) pulse_frame();
      n_cmp++;
      if (charge0 !== 2'd2) begin
         n_bad++;
         $display("FAIL rel_charge2: got %0d want 2", charge0);
      end
      draw_req = 1'b0;
      tick();
      n_cmp++;
      if (fired0 !== 1'b1 || charge0 !== 2'd0) begin
         n_bad++;
         $display("FAIL rel_fire: got fired=%b charge=%0d want fired=1 charge=0", fired0, charge0);
      end
      tick();
      n_cmp++;
      if (fired0 !== 1'b0) begin
         n_bad++;
         $display("FAIL rel_fire_width: got %b want 0", fired0);
      end
      draw_req = 1'b1;
      repeat (13) pulse_frame();
      n_cmp++;
      if (charge0 !== 2'd0) begin
         n_bad++;
         $display("FAIL rel_ignore: got charge %0d want 0", charge0);
      end
      pulse_frame();
      n_cmp++;
      if (charge0 !== 2'd1) begin
         n_bad++;
         $display("FAIL rel_idle_recharge: got charge %0d want 1", charge0);
      end
      repeat (7) pulse_frame();
      frame_start = 1'b1; draw_req = 1'b0;
      tick();
      frame_start = 1'b0;
      n_cmp++;
      if (fired0 !== 1'b1 || charge0 !== 2'd0) begin
         n_bad++;
         $display("FAIL rel_priority: got fired=%b charge=%0d want fired=1 charge=0", fired0, charge0);
      end
      repeat (6) pulse_frame();
      $display("test_release: done");
   endtask

   task automatic test_charge();
      int exp_c;
      DrawX = 10'd428; DrawY = 10'd327;
      draw_req = 1'b1;
      tick();
      for (int k = 1; k <= 40; k++) begin
         pulse_frame();
         exp_c = (k < 8) ? 0 : (k < 16) ? 1 : (k < 24) ? 2 : 3;
         if (k == 7 || k == 8 || k == 15 || k == 16 || k == 24 || k == 40) begin
            n_cmp++;
            if (charge0 !== 2'(exp_c)) begin
               n_bad++;
               $display("FAIL charge_f%0d: got %0d want %0d", k, charge0, exp_c);
            end
         end
         if (k == 8 || k == 9 || k == 16 || k == 17 || k == 40) begin
            exp_c = (k == 8) ? 0 : (k == 9 || k == 16) ? 5775 : (k == 17) ? 11550 : 17325;
            n_cmp++;
            if (rom_addr0 !== 15'(exp_c)) begin
               n_bad++;
               $display("FAIL disp_addr_f%0d: got %0d want %0d", k, rom_addr0, exp_c);
            end
         end
      end
      n_cmp++;
      if (fired0 !== 1'b0) begin
         n_bad++;
         $display("FAIL charge_nofire: got %b want 0", fired0);
      end
      $display("test_charge: charge=%0d addr=%0d", charge0, rom_addr0);
   endtask

   task automatic test_reset_mid();
      logic saw_fire;
      draw_req = 1'b0;
      tick();
      repeat (6) pulse_frame();
      draw_req = 1'b1;
      tick();
      repeat (9) pulse_frame();
      DrawX = 10'd440; DrawY = 10'd340; rom_q0 = 3'd3; blank = 1'b1;
      repeat (3) tick();
      n_cmp++;
      if (pix_opaque0 !== 1'b1 || charge0 !== 2'd1) begin
         n_bad++;
         $display("FAIL pre_reset: got op=%b charge=%0d want op=1 charge=1", pix_opaque0, charge0);
      end
      #2;
      reset_n = 1'b0; draw_req = 1'b0;
      #1;
      n_cmp++;
      if ({rom_addr0, pix_idx0, pix_opaque0, blank_d0, charge0, fired0} !== 24'd0) begin
         n_bad++;
         $display("FAIL mid_reset_dut0: got addr=%0d idx=%0d op=%b bd=%b ch=%0d f=%b want all 0",
                  rom_addr0, pix_idx0, pix_opaque0, blank_d0, charge0, fired0);
      end
      @(posedge vga_clk);
      #1;
      reset_n = 1'b1;
      saw_fire = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         saw_fire = saw_fire | fired0;
      end
      n_cmp++;
      if (saw_fire !== 1'b0 || charge0 !== 2'd0) begin
         n_bad++;
         $display("FAIL post_reset: got fired_seen=%b charge=%0d want 0 0", saw_fire, charge0);
      end
      $display("test_reset_mid: done");
   endtask

   initial begin
      test_reset();
      test_addr();
      test_latency();
      test_opacity();
      test_blank();
      test_release();
      test_charge();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
